// File: rtl/call_stack_if.sv
`default_nettype none
// ============================================================================
// Module      : call_stack_if
// Description : Control-unit <-> return-address stack signal bundle.
//               The master drives call/return requests and the PC value.
//               The slave (the stack) reports its top entry and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface call_stack_if #(
  parameter int AW    = 16,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          push;
  logic          pop;
  logic [AW-1:0] pc_in;
  logic          clr_err;
  logic [AW-1:0] top_addr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          ovf;
  logic          unf;

  modport master (
    output push, pop, pc_in, clr_err,
    input  top_addr, count, full, empty, ovf, unf
  );

  modport slave (
    input  push, pop, pc_in, clr_err,
    output top_addr, count, full, empty, ovf, unf
  );
endinterface
`default_nettype wire

// File: rtl/call_stack.sv
`default_nettype none
// ============================================================================
// Module      : call_stack
// Description : Parametrised return-address stack. A call pushes
//               pc_in + RET_OFFSET and a return pops. The current top is
//               presented combinationally on top_addr for the PC-write mux.
//               Full, empty, occupancy and sticky overflow/underflow flags
//               are reported to the control unit.
// Revision    : 1.0 - initial release
// ============================================================================
module call_stack #(
  parameter int AW         = 16,
  parameter int DEPTH      = 8,
  parameter int RET_OFFSET = 1,
  parameter int OVF_WRAP   = 0
) (
  input  wire logic   clk,
  input  wire logic   rst,
  call_stack_if.slave bus
);

  localparam int            CW     = $clog2(DEPTH + 1);
  localparam int            PW     = $clog2(DEPTH);
  localparam logic [PW-1:0] c_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

  // Storage: entries are never cleared, only the pointer/count define validity.
  logic [AW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_unf;

  logic [PW-1:0] w_wp_inc;
  logic [PW-1:0] w_wp_dec;
  logic          w_full;
  logic          w_empty;
  logic [AW-1:0] w_ret;
  logic          w_both;
  logic          w_push_only;
  logic          w_pop_only;
  logic          w_we;
  logic [PW-1:0] w_waddr;

  // Pointers wrap modulo DEPTH explicitly so non-power-of-two depths work.
  assign w_wp_inc    = (r_wp == c_LAST) ? '0 : r_wp + PW'(1);
  assign w_wp_dec    = (r_wp == '0) ? c_LAST : r_wp - PW'(1);
  assign w_full      = (r_count == c_FULL);
  assign w_empty     = (r_count == '0);
  assign w_ret       = bus.pc_in + AW'(RET_OFFSET);
  assign w_both      = bus.push & bus.pop;
  assign w_push_only = bus.push & ~bus.pop;
  assign w_pop_only  = bus.pop & ~bus.push;

  // Decode the array write: replace-top on push+pop, append on push otherwise.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_wp;
    if (!rst) begin
      if (w_both) begin
        w_we    = 1'b1;
        w_waddr = w_empty ? r_wp : w_wp_dec;
      end else if (w_push_only) begin
        w_we    = !w_full || (OVF_WRAP != 0);
        w_waddr = r_wp;
      end
    end
  end

  // Array write port; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_ret;
    end
  end

  // Pointer, occupancy and sticky error flags; a same-cycle error beats clr_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (bus.clr_err) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end
      if (w_both) begin
        // Non-empty: top replaced in place, no pointer change, never an overflow.
        if (w_empty) begin
          r_wp    <= w_wp_inc;
          r_count <= CW'(1);
          r_unf   <= 1'b1;
        end
      end else if (w_push_only) begin
        if (!w_full) begin
          r_wp    <= w_wp_inc;
          r_count <= r_count + CW'(1);
        end else begin
          r_ovf <= 1'b1;
          // Wrap policy: oldest entry is overwritten, count stays at DEPTH.
          if (OVF_WRAP != 0) begin
            r_wp <= w_wp_inc;
          end
        end
      end else if (w_pop_only) begin
        if (!w_empty) begin
          r_wp    <= w_wp_dec;
          r_count <= r_count - CW'(1);
        end else begin
          r_unf <= 1'b1;
        end
      end
    end
  end

  assign bus.top_addr = w_empty ? '0 : r_mem[w_wp_dec];
  assign bus.count    = r_count;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.ovf      = r_ovf;
  assign bus.unf      = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_call_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_call_stack
// Description : Self-checking bench for call_stack. Two instances (reject and
//               wrap overflow policy) receive identical stimulus; a shifting
//               array reference model feeds a scoreboard queue, and a vector
//               table plus hand sequences check hand-derived constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_call_stack;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  call_stack_if #(.AW(16), .DEPTH(8)) if0 ();
  call_stack_if #(.AW(16), .DEPTH(8)) if1 ();

  call_stack #(.AW(16), .DEPTH(8), .RET_OFFSET(1), .OVF_WRAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  call_stack #(.AW(16), .DEPTH(8), .RET_OFFSET(1), .OVF_WRAP(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] top;
    int          cnt;
    bit          full;
    bit          empty;
    bit          ovf;
    bit          unf;
  } exp_t;

  exp_t sbq[$];

  // Reference model: entries kept bottom-to-top in a shifting array.
  logic [15:0] mst  [2][8];
  int          mcnt [2];
  bit          movf [2];
  bit          munf [2];

  typedef struct {
    bit          p;
    bit          q;
    bit          clr;
    bit          r;
    logic [15:0] pc;
    logic [15:0] top;
    int          cnt;
    bit          ovf;
    bit          unf;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_step(input int k, input bit p, input bit q,
                            input logic [15:0] pc, input bit clr, input bit r);
    logic [15:0] v;
    v = pc + 16'd1;
    if (r) begin
      mcnt[k] = 0; movf[k] = 1'b0; munf[k] = 1'b0;
    end else begin
      if (clr) begin movf[k] = 1'b0; munf[k] = 1'b0; end
      if (p && q) begin
        if (mcnt[k] > 0) mst[k][mcnt[k]-1] = v;
        else begin mst[k][0] = v; mcnt[k] = 1; munf[k] = 1'b1; end
      end else if (p) begin
        if (mcnt[k] < 8) begin mst[k][mcnt[k]] = v; mcnt[k]++; end
        else begin
          movf[k] = 1'b1;
          if (k == 1) begin
            for (int j = 0; j < 7; j++) mst[k][j] = mst[k][j+1];
            mst[k][7] = v;
          end
        end
      end else if (q) begin
        if (mcnt[k] > 0) mcnt[k]--;
        else munf[k] = 1'b1;
      end
    end
  endtask

  function automatic exp_t model_exp(input int k);
    exp_t e;
    e.cnt   = mcnt[k];
    e.top   = (mcnt[k] > 0) ? mst[k][mcnt[k]-1] : 16'h0000;
    e.full  = (mcnt[k] == 8);
    e.empty = (mcnt[k] == 0);
    e.ovf   = movf[k];
    e.unf   = munf[k];
    return e;
  endfunction

  task automatic check_dut(input int k, input exp_t e);
    string pfx;
    pfx = $sformatf("dut%0d", k);
    if (k == 0) begin
      chk({pfx, " top_addr"}, int'(if0.top_addr), int'(e.top));
      chk({pfx, " count"},    int'(if0.count),    e.cnt);
      chk({pfx, " full"},     int'(if0.full),     int'(e.full));
      chk({pfx, " empty"},    int'(if0.empty),    int'(e.empty));
      chk({pfx, " ovf"},      int'(if0.ovf),      int'(e.ovf));
      chk({pfx, " unf"},      int'(if0.unf),      int'(e.unf));
    end else begin
      chk({pfx, " top_addr"}, int'(if1.top_addr), int'(e.top));
      chk({pfx, " count"},    int'(if1.count),    e.cnt);
      chk({pfx, " full"},     int'(if1.full),     int'(e.full));
      chk({pfx, " empty"},    int'(if1.empty),    int'(e.empty));
      chk({pfx, " ovf"},      int'(if1.ovf),      int'(e.ovf));
      chk({pfx, " unf"},      int'(if1.unf),      int'(e.unf));
    end
  endtask

  // One clock of stimulus: drive, predict, then compare after the edge.
  task automatic step(input bit p, input bit q, input logic [15:0] pc,
                      input bit clr, input bit r);
    exp_t e0, e1;
    @(negedge clk);
    rst = r;
    if0.push = p; if0.pop = q; if0.pc_in = pc; if0.clr_err = clr;
    if1.push = p; if1.pop = q; if1.pc_in = pc; if1.clr_err = clr;
    model_step(0, p, q, pc, clr, r);
    model_step(1, p, q, pc, clr, r);
    sbq.push_back(model_exp(0));
    sbq.push_back(model_exp(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    if0.push = 1'b0; if0.pop = 1'b0; if0.clr_err = 1'b0;
    if1.push = 1'b0; if1.pop = 1'b0; if1.clr_err = 1'b0;
    e0 = sbq.pop_front();
    e1 = sbq.pop_front();
    check_dut(0, e0);
    check_dut(1, e1);
  endtask

  task automatic addv(input bit p, input bit q, input bit clr, input bit r,
                      input logic [15:0] pc, input logic [15:0] top,
                      input int cnt, input bit ovf, input bit unf);
    vec_t v;
    v.p = p; v.q = q; v.clr = clr; v.r = r; v.pc = pc;
    v.top = top; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
    vt.push_back(v);
  endtask

  initial begin
    if0.push = 1'b0; if0.pop = 1'b0; if0.pc_in = '0; if0.clr_err = 1'b0;
    if1.push = 1'b0; if1.pop = 1'b0; if1.pc_in = '0; if1.clr_err = 1'b0;
    for (int k = 0; k < 2; k++) begin mcnt[k] = 0; movf[k] = 0; munf[k] = 0; end

    //    p  q  clr r  pc        top       cnt ovf unf
    addv(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);
    addv(1, 0, 0, 0, 16'h0010, 16'h0011, 1, 0, 0);
    addv(1, 0, 0, 0, 16'h0020, 16'h0021, 2, 0, 0);
    addv(1, 0, 0, 0, 16'h0030, 16'h0031, 3, 0, 0);
    addv(0, 1, 0, 0, 16'h0000, 16'h0021, 2, 0, 0);
    addv(0, 1, 0, 0, 16'h0000, 16'h0011, 1, 0, 0);
    addv(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    addv(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 1);
    addv(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);
    addv(0, 1, 1, 0, 16'h0000, 16'h0000, 0, 0, 1);
    addv(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);
    addv(1, 0, 0, 0, 16'h0010, 16'h0011, 1, 0, 0);
    addv(1, 0, 0, 0, 16'h0020, 16'h0021, 2, 0, 0);
    addv(1, 1, 0, 0, 16'h0100, 16'h0101, 2, 0, 0);
    addv(0, 1, 0, 0, 16'h0000, 16'h0011, 1, 0, 0);
    addv(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    addv(1, 1, 0, 0, 16'h0200, 16'h0201, 1, 0, 1);
    addv(0, 0, 1, 0, 16'h0000, 16'h0201, 1, 0, 0);
    addv(1, 0, 0, 0, 16'h0001, 16'h0002, 2, 0, 0);
    addv(1, 0, 0, 0, 16'h0002, 16'h0003, 3, 0, 0);
    addv(1, 0, 0, 0, 16'h0003, 16'h0004, 4, 0, 0);
    addv(1, 0, 0, 0, 16'h0004, 16'h0005, 5, 0, 0);
    addv(1, 0, 0, 1, 16'h0005, 16'h0000, 0, 0, 0);
    addv(1, 0, 0, 0, 16'hFFFF, 16'h0000, 1, 0, 0);

    foreach (vt[i]) begin
      step(vt[i].p, vt[i].q, vt[i].pc, vt[i].clr, vt[i].r);
      chk($sformatf("vec%0d top_addr", i), int'(if0.top_addr), int'(vt[i].top));
      chk($sformatf("vec%0d count", i),    int'(if0.count),    vt[i].cnt);
      chk($sformatf("vec%0d empty", i),    int'(if0.empty),    int'(vt[i].cnt == 0));
      chk($sformatf("vec%0d ovf", i),      int'(if0.ovf),      int'(vt[i].ovf));
      chk($sformatf("vec%0d unf", i),      int'(if0.unf),      int'(vt[i].unf));
    end

    // Overflow under both policies: ten pushes of pc_in = 0..9.
    step(0, 0, 16'h0000, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 16'(i), 0, 0);
    chk("rej full",  int'(if0.full),     1);
    chk("rej count", int'(if0.count),    8);
    chk("rej ovf",   int'(if0.ovf),      1);
    chk("rej top",   int'(if0.top_addr), 8);
    chk("wrap count", int'(if1.count),    8);
    chk("wrap ovf",   int'(if1.ovf),      1);
    chk("wrap top",   int'(if1.top_addr), 10);
    // Return address is top_addr during the pop cycle.
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("rej pop%0d", j),  int'(if0.top_addr), 8 - j);
      chk($sformatf("wrap pop%0d", j), int'(if1.top_addr), 10 - j);
      step(0, 1, 16'h0000, 0, 0);
    end
    chk("rej drained empty",  int'(if0.empty),    1);
    chk("rej drained top",    int'(if0.top_addr), 0);
    chk("wrap drained empty", int'(if1.empty),    1);
    chk("wrap drained top",   int'(if1.top_addr), 0);

    // Full stack: push+pop replaces the top and must not raise ovf.
    step(0, 0, 16'h0000, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 16'(16'h0040 + i), 0, 0);
    step(1, 1, 16'h0300, 0, 0);
    chk("full swap top",   int'(if0.top_addr), 16'h0301);
    chk("full swap count", int'(if0.count),    8);
    chk("full swap ovf",   int'(if0.ovf),      0);
    // Overflow set beats a same-cycle clear.
    step(1, 0, 16'h0000, 1, 0);
    chk("ovf set over clr", int'(if0.ovf), 1);

    // Randomised traffic checked only against the model.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           16'($urandom), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 63) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
